// File: rtl/bf16_from_int.sv
// Serial 32-bit integer to bfloat16 encoder: shifts the magnitude left one bit
// per cycle until the MSB is set, then rounds to nearest-even in a single cycle.
module bf16_from_int #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mag;
  logic [7:0]  exp_r;
  logic        sign;

  logic        sign_in;
  logic [31:0] mag_in;
  logic        mag_in_zero;

  // 2^31 is representable as an unsigned magnitude, so negating INT_MIN is safe.
  assign sign_in     = SIGNED & a[31];
  assign mag_in      = sign_in ? 32'(-$signed(a)) : a;
  assign mag_in_zero = (mag_in == 32'd0);

  // Round a normalized magnitude (bit 31 set) to 7 fraction bits, ties to even.
  // A carry out of the fraction bumps the exponent and clears the fraction.
  function automatic logic [14:0] round_rne(input logic [31:0] m, input logic [7:0] e);
    logic       inc;
    logic [7:0] sum;
    inc = m[23] & ((|m[22:0]) | m[24]);
    sum = {1'b0, m[30:24]} + {7'd0, inc};
    round_rne = sum[7] ? {e + 8'd1, 7'd0} : {e, sum[6:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !mag_in_zero) state_nxt = NORM;
      NORM:    if (mag[31]) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag   <= 32'd0;
      exp_r <= 8'd0;
      sign  <= 1'b0;
      out   <= 16'h0000;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            sign  <= sign_in;
            mag   <= mag_in;
            exp_r <= 8'd158;
            // Zero bypasses normalization; the sign is dropped so no -0 appears.
            if (mag_in_zero) begin
              out  <= 16'h0000;
              done <= 1'b1;
            end
          end
        end
        NORM: begin
          if (!mag[31]) begin
            mag   <= mag << 1;
            exp_r <= exp_r - 8'd1;
          end
        end
        ROUND: begin
          out  <= {sign, round_rne(mag, exp_r)};
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == NORM) || (state == ROUND);

endmodule

// File: tb/tb_bf16_from_int.sv
// Directed and random checks of bf16_from_int in signed and unsigned builds,
// driven side by side from one shared en/a stimulus stream.
module tb_bf16_from_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic        busy_s, done_s, busy_u, done_u;
  logic [15:0] out_s, out_u;

  int checks   = 0;
  int failures = 0;

  bf16_from_int #(.SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .en(en), .a(a), .busy(busy_s), .done(done_s), .out(out_s)
  );
  bf16_from_int #(.SIGNED(1'b0)) u_u (
    .clk(clk), .rst(rst), .en(en), .a(a), .busy(busy_u), .done(done_u), .out(out_u)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic launch(input logic [31:0] v);
    a  = v;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Wait for both results. k counts edges since the accept edge (edge 0).
  // Optionally starts a new operation in the done cycle.
  task automatic collect(input int k0, input logic nxt_en, input logic [31:0] nxt_a,
                         output logic [15:0] os, output logic [15:0] ou,
                         output int ks, output int ku, output int ps, output int pu,
                         output logic bs);
    ks = -1; ku = -1; ps = 0; pu = 0; os = 16'h0; ou = 16'h0; bs = 1'bx;
    for (int k = k0; k <= k0 + 40; k++) begin
      if (k > k0) tick();
      if (done_s) begin
        ps++;
        if (ks < 0) begin ks = k; os = out_s; bs = busy_s; end
      end
      if (done_u) begin
        pu++;
        if (ku < 0) begin ku = k; ou = out_u; end
      end
      if (ks >= 0 && ku >= 0) break;
    end
    if (nxt_en) begin
      a  = nxt_a;
      en = 1'b1;
    end
    tick();
    en = 1'b0;
    if (done_s) ps++;
    if (done_u) pu++;
  endtask

  task automatic check_result(input string tag, input logic [15:0] os, input logic [15:0] ou,
                              input int ks, input int ku, input int ps, input int pu,
                              input logic [15:0] es, input int kse,
                              input logic [15:0] eu, input int kue);
    chk({tag, "_out_s"}, 32'(os), 32'(es));
    chk({tag, "_lat_s"}, ks, kse);
    chk({tag, "_out_u"}, 32'(ou), 32'(eu));
    chk({tag, "_lat_u"}, ku, kue);
    chk({tag, "_pulses_s"}, ps, 1);
    chk({tag, "_pulses_u"}, pu, 1);
  endtask

  task automatic run_dir(input string tag, input logic [31:0] v,
                         input logic [15:0] es, input int kse,
                         input logic [15:0] eu, input int kue);
    logic [15:0] os, ou;
    int ks, ku, ps, pu;
    logic bs;
    launch(v);
    collect(0, 1'b0, 32'h0, os, ou, ks, ku, ps, pu, bs);
    check_result(tag, os, ou, ks, ku, ps, pu, es, kse, eu, kue);
    chk({tag, "_busy_in_done"}, 32'(bs), 32'd0);
  endtask

  // Exact integer to RNE bfloat16 by arithmetic on the full-width magnitude.
  function automatic logic [15:0] ref_bf16(input logic [31:0] v, input bit sgn, output int lz);
    logic              s;
    longint unsigned   m, q, rem, half;
    int                p, e, sh;
    s = sgn && v[31];
    m = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    lz = 0;
    if (m == 0) return 16'h0000;
    p = 31;
    while (m[p] == 1'b0) p--;
    lz = 31 - p;
    e  = 127 + p;
    if (p <= 7) begin
      q = m << (7 - p);
    end else begin
      sh   = p - 7;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 256) begin
        q = 128;
        e++;
      end
    end
    return {s, e[7:0], q[6:0]};
  endfunction

  initial begin
    logic [15:0] os, ou, es, eu;
    logic [31:0] r;
    int ks, ku, ps, pu, lzs, lzu, nd;
    logic bs;

    rst = 1'b1;
    en  = 1'b0;
    a   = 32'h0;
    tick();
    tick();
    chk("rst_busy_s", 32'(busy_s), 32'd0);
    chk("rst_done_s", 32'(done_s), 32'd0);
    chk("rst_out_s",  32'(out_s),  32'd0);
    chk("rst_out_u",  32'(out_u),  32'd0);
    rst = 1'b0;
    tick();

    run_dir("exact255", 32'd255, 16'h437F, 26, 16'h437F, 26);
    run_dir("tie_even257", 32'd257, 16'h4380, 25, 16'h4380, 25);
    run_dir("tie_odd259", 32'd259, 16'h4382, 25, 16'h4382, 25);
    run_dir("all_ones", 32'hFFFF_FFFF, 16'hBF80, 33, 16'h4F80, 2);
    run_dir("int_min", 32'h8000_0000, 16'hCF00, 2, 16'h4F00, 2);
    run_dir("zero", 32'h0, 16'h0000, 0, 16'h0000, 0);
    run_dir("neg_zero_free", 32'hFFFF_FFFE, 16'hC000, 32, 16'h4F80, 2);

    // Abort mid-normalization: reset must clear outputs without a clock edge.
    run_dir("pre_reset", 32'd255, 16'h437F, 26, 16'h437F, 26);
    launch(32'd1);
    repeat (5) tick();
    chk("mid_busy_s", 32'(busy_s), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_busy_s", 32'(busy_s), 32'd0);
    chk("async_done_s", 32'(done_s), 32'd0);
    chk("async_out_s",  32'(out_s),  32'd0);
    chk("async_out_u",  32'(out_u),  32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_s || done_u) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    run_dir("one", 32'd1, 16'h3F80, 33, 16'h3F80, 33);

    // en while busy is ignored; en in the done cycle is accepted.
    launch(32'd257);
    chk("hs_busy_after_en", 32'(busy_s), 32'd1);
    repeat (3) tick();
    a  = 32'd5;
    en = 1'b1;
    tick();
    en = 1'b0;
    a  = 32'h0;
    collect(4, 1'b1, 32'd259, os, ou, ks, ku, ps, pu, bs);
    check_result("hs_first", os, ou, ks, ku, ps, pu, 16'h4380, 25, 16'h4380, 25);
    collect(0, 1'b0, 32'h0, os, ou, ks, ku, ps, pu, bs);
    check_result("hs_b2b", os, ou, ks, ku, ps, pu, 16'h4382, 25, 16'h4382, 25);

    for (int n = 0; n < 10000; n++) begin
      r = $urandom;
      if ($urandom_range(0, 15) == 0) r = r >> $urandom_range(0, 31);
      es = ref_bf16(r, 1'b1, lzs);
      eu = ref_bf16(r, 1'b0, lzu);
      launch(r);
      collect(0, 1'b0, 32'h0, os, ou, ks, ku, ps, pu, bs);
      check_result("rand", os, ou, ks, ku, ps, pu,
                   es, (es == 16'h0000) ? 0 : lzs + 2,
                   eu, (eu == 16'h0000) ? 0 : lzu + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
